// File: rtl/pieo_pre_enq_default.sv
// Enqueue side of the PIEO scheduler: tracks per-FIFO lifecycle, round-robin picks
// a backlogged FIFO that has no entry in the PIEO, and issues {time, rank, id}.
module pieo_pre_enq_default #(
    parameter int NUM_QUEUES = 3,
    parameter int ID_LOG     = $clog2(NUM_QUEUES),
    parameter int RANK_LOG   = 1,
    parameter int TIME_LOG   = 1,
    localparam int ELEM_W    = ID_LOG + RANK_LOG + TIME_LOG
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en_in,
    input  logic [NUM_QUEUES-1:0]          fifo_tvalid,
    input  logic [NUM_QUEUES*RANK_LOG-1:0] queue_rank,
    input  logic                           pieo_ready,
    input  logic                           pieo_full,
    output logic                           pieo_enq_trigger,
    output logic [ELEM_W-1:0]              pieo_enq_element,
    input  logic                           pieo_deq_valid,
    input  logic [ELEM_W-1:0]              pieo_deq_element,
    input  logic [NUM_QUEUES-1:0]          pe_tlast,
    input  logic [ID_LOG-1:0]              deq_sel,
    input  logic                           deq_en,
    output logic                           fifos_not_enq_flag
);

    localparam logic [1:0] QS_FREE    = 2'd0;
    localparam logic [1:0] QS_LISTED  = 2'd1;
    localparam logic [1:0] QS_SERVING = 2'd2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [NUM_QUEUES-1:0][1:0] qs_q, qs_d;
    logic [0:0]                 state_q, state_d;
    logic [ID_LOG-1:0]          rr_ptr_q, rr_ptr_d;
    logic                       trig_q, trig_d;
    logic [ELEM_W-1:0]          elem_q, elem_d;

    logic [NUM_QUEUES-1:0] eligible;
    logic                  found;
    logic [ID_LOG-1:0]     win;
    logic [RANK_LOG-1:0]   win_rank;
    logic                  fire;
    logic [ID_LOG-1:0]     deq_id;
    logic                  deq_invalid;

    assign deq_id      = pieo_deq_element[ID_LOG-1:0];
    assign deq_invalid = &pieo_deq_element;

    always_comb begin
        eligible = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            eligible[q] = (qs_q[q] == QS_FREE) && fifo_tvalid[q];
        end
    end

    // Two passes give cyclic priority: first the ids at or after rr_ptr, then the wrap.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_rank = '0;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (!found && eligible[q] && (ID_LOG'(q) >= rr_ptr_q)) begin
                found    = 1'b1;
                win      = ID_LOG'(q);
                win_rank = queue_rank[q*RANK_LOG +: RANK_LOG];
            end
        end
        for (int q = 0; q < NUM_QUEUES; q++) begin
            if (!found && eligible[q]) begin
                found    = 1'b1;
                win      = ID_LOG'(q);
                win_rank = queue_rank[q*RANK_LOG +: RANK_LOG];
            end
        end
    end

    assign fire = (state_q == ST_IDLE) && found && en_in && pieo_ready && !pieo_full;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        trig_d   = 1'b0;
        elem_d   = elem_q;
        if (state_q == ST_IDLE) begin
            if (fire) begin
                state_d  = ST_WAIT;
                trig_d   = 1'b1;
                elem_d   = {{TIME_LOG{1'b0}}, win_rank, win};
                rr_ptr_d = (win == ID_LOG'(NUM_QUEUES - 1)) ? '0 : win + ID_LOG'(1);
            end
        end else begin
            if (pieo_ready) begin
                state_d = ST_IDLE;
            end
        end
    end

    // An enqueue only ever targets a FREE queue, so it never collides with the
    // snoop-driven transitions of LISTED or SERVING queues.
    always_comb begin
        qs_d = qs_q;
        for (int q = 0; q < NUM_QUEUES; q++) begin
            case (qs_q[q])
                QS_FREE: begin
                    if (fire && (win == ID_LOG'(q))) qs_d[q] = QS_LISTED;
                end
                QS_LISTED: begin
                    if (pieo_deq_valid && (deq_id == ID_LOG'(q))) begin
                        qs_d[q] = (!deq_invalid && fifo_tvalid[q]) ? QS_SERVING : QS_FREE;
                    end
                end
                QS_SERVING: begin
                    if (deq_en && (deq_sel == ID_LOG'(q)) && pe_tlast[q]) qs_d[q] = QS_FREE;
                end
                default: qs_d[q] = QS_FREE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            qs_q     <= '0;
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            trig_q   <= 1'b0;
            elem_q   <= '0;
        end else begin
            qs_q     <= qs_d;
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            trig_q   <= trig_d;
            elem_q   <= elem_d;
        end
    end

    assign pieo_enq_trigger   = trig_q;
    assign pieo_enq_element   = elem_q;
    assign fifos_not_enq_flag = (|eligible) || (state_q == ST_WAIT);

endmodule
